niosii_pio_multi: RTL and testbench

Parametrised N-channel Avalon-MM PIO slave for the Nios II system. Successor to the single-bit reset/button PIO.
- Adds per-channel output and direction registers.
- Adds atomic set/clear of outputs, per-bit write-1-to-clear edge capture and a selectable edge/level interrupt mode.
- Sits on the Nios II data master interconnect. Drives one IRQ line to the CPU.

---
 rtl/niosii_pio_pkg.sv | 18 +
 rtl/niosii_pio_multi_if.sv | 13 +
 rtl/niosii_pio_sync_edge.sv | 43 ++++
 rtl/niosii_pio_multi.sv | 98 +++++++++
 tb/tb_niosii_pio_multi.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/niosii_pio_pkg.sv
// rtl/niosii_pio_pkg.sv - shared register map and mode encodings for the multi-channel PIO
package niosii_pio_pkg;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_DIR      = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR   = 3'd5;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    localparam int IRQ_EDGE  = 0;
    localparam int IRQ_LEVEL = 1;

endpackage

// File: rtl/niosii_pio_multi_if.sv
// rtl/niosii_pio_multi_if.sv - Avalon-MM slave register bus for the multi-channel PIO
interface niosii_pio_multi_if;

    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);

endinterface

// File: rtl/niosii_pio_sync_edge.sv
// rtl/niosii_pio_sync_edge.sv - two-flop input synchroniser plus one history stage for edge detection
module niosii_pio_sync_edge
    import niosii_pio_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int EDGE_TYPE = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] sync_in,
    output logic [WIDTH-1:0] edge_det
);

    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic [WIDTH-1:0] d3;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            d1 <= '0;
            d2 <= '0;
            d3 <= '0;
        end else begin
            d1 <= in_port;
            d2 <= d1;
            d3 <= d2;
        end
    end

    assign sync_in = d2;
    assign rise    = d2 & ~d3;
    assign fall    = ~d2 & d3;

    always_comb begin
        edge_det = rise;
        if (EDGE_TYPE == EDGE_FALL) edge_det = fall;
        else if (EDGE_TYPE == EDGE_ANY) edge_det = rise | fall;
    end

endmodule

// File: rtl/niosii_pio_multi.sv
// rtl/niosii_pio_multi.sv - N-channel PIO slave: data/dir/mask/edge-capture registers, set/clear, single IRQ
module niosii_pio_multi
    import niosii_pio_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               EDGE_TYPE = EDGE_RISE,
    parameter int               IRQ_TYPE  = IRQ_EDGE,
    parameter logic [WIDTH-1:0] RESET_OUT = '0,
    parameter logic [WIDTH-1:0] RESET_DIR = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    niosii_pio_multi_if.slave    bus,
    output logic                 irq,
    input  logic [WIDTH-1:0]     in_port,
    output logic [WIDTH-1:0]     out_port,
    output logic [WIDTH-1:0]     oe
);

    logic             wr;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] out_reg;
    logic [WIDTH-1:0] dir;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] cap;
    logic [WIDTH-1:0] cap_clr;
    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] edge_det;
    logic [31:0]      rd_next;
    logic             unused_wd;

    assign wr        = bus.chipselect & ~bus.write_n;
    assign wd        = bus.writedata[WIDTH-1:0];
    assign unused_wd = ^bus.writedata;
    assign cap_clr   = (wr && bus.address == ADDR_EDGE_CAP) ? wd : '0;

    niosii_pio_sync_edge #(
        .WIDTH     (WIDTH),
        .EDGE_TYPE (EDGE_TYPE)
    ) u_sync_edge (
        .clk      (clk),
        .reset    (reset),
        .in_port  (in_port),
        .sync_in  (sync_in),
        .edge_det (edge_det)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            out_reg <= RESET_OUT;
            dir     <= RESET_DIR;
            mask    <= '0;
        end else if (wr) begin
            case (bus.address)
                ADDR_DATA:     out_reg <= wd;
                ADDR_DIR:      dir     <= wd;
                ADDR_IRQ_MASK: mask    <= wd;
                ADDR_OUTSET:   out_reg <= out_reg | wd;
                ADDR_OUTCLR:   out_reg <= out_reg & ~wd;
                default: ;
            endcase
        end
    end

    // A fresh edge overrides a simultaneous write-1-to-clear so no event is lost.
    always_ff @(posedge clk) begin
        if (reset) cap <= '0;
        else       cap <= edge_det | (cap & ~cap_clr);
    end

    always_comb begin
        rd_next = '0;
        case (bus.address)
            ADDR_DATA:     rd_next[WIDTH-1:0] = (sync_in & ~dir) | (out_reg & dir);
            ADDR_DIR:      rd_next[WIDTH-1:0] = dir;
            ADDR_IRQ_MASK: rd_next[WIDTH-1:0] = mask;
            ADDR_EDGE_CAP: rd_next[WIDTH-1:0] = cap;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) bus.readdata <= '0;
        else       bus.readdata <= rd_next;
    end

    generate
        if (IRQ_TYPE == IRQ_LEVEL) begin : g_irq_level
            assign irq = |(sync_in & ~dir & mask);
        end else begin : g_irq_edge
            assign irq = |(cap & mask);
        end
    endgenerate

    assign out_port = out_reg;
    assign oe       = dir;

endmodule

// File: tb/tb_niosii_pio_multi.sv
// tb/tb_niosii_pio_multi.sv - directed self-checking bench for niosii_pio_multi
module tb_niosii_pio_multi;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in0, in1;
    logic [7:0] out0, out1, oe0, oe1;
    logic       irq0, irq1;
    logic [31:0] rd;
    int checks = 0;
    int failures = 0;

    niosii_pio_multi_if bus0 ();
    niosii_pio_multi_if bus1 ();

    always #5 clk = ~clk;

    niosii_pio_multi #(.WIDTH(8), .EDGE_TYPE(0), .IRQ_TYPE(0),
                       .RESET_OUT(8'hA5), .RESET_DIR(8'h3C)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0), .irq(irq0),
        .in_port(in0), .out_port(out0), .oe(oe0));

    niosii_pio_multi #(.WIDTH(8), .EDGE_TYPE(2), .IRQ_TYPE(1),
                       .RESET_OUT(8'h00), .RESET_DIR(8'h00)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1), .irq(irq1),
        .in_port(in1), .out_port(out1), .oe(oe1));

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr0(input logic [2:0] a, input logic [31:0] d);
        bus0.address = a; bus0.writedata = d; bus0.chipselect = 1'b1; bus0.write_n = 1'b0;
        tick();
        bus0.chipselect = 1'b0; bus0.write_n = 1'b1;
    endtask

    task automatic rd0(input logic [2:0] a, output logic [31:0] d);
        bus0.address = a; bus0.chipselect = 1'b1; bus0.write_n = 1'b1;
        tick();
        bus0.chipselect = 1'b0;
        d = bus0.readdata;
    endtask

    task automatic wr1(input logic [2:0] a, input logic [31:0] d);
        bus1.address = a; bus1.writedata = d; bus1.chipselect = 1'b1; bus1.write_n = 1'b0;
        tick();
        bus1.chipselect = 1'b0; bus1.write_n = 1'b1;
    endtask

    task automatic rd1(input logic [2:0] a, output logic [31:0] d);
        bus1.address = a; bus1.chipselect = 1'b1; bus1.write_n = 1'b1;
        tick();
        bus1.chipselect = 1'b0;
        d = bus1.readdata;
    endtask

    task automatic test_reset();
        reset = 1'b1; in0 = 8'h00; in1 = 8'h00;
        bus0.address = 3'd0; bus0.chipselect = 1'b0; bus0.write_n = 1'b1; bus0.writedata = '0;
        bus1.address = 3'd0; bus1.chipselect = 1'b0; bus1.write_n = 1'b1; bus1.writedata = '0;
        tick(3);
        checks++; if (out0 !== 8'hA5) begin failures++; $display("FAIL reset_out got=%h exp=a5", out0); end
        checks++; if (oe0 !== 8'h3C) begin failures++; $display("FAIL reset_oe got=%h exp=3c", oe0); end
        checks++; if (irq0 !== 1'b0 || irq1 !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b%b exp=00", irq0, irq1); end
        checks++; if (bus0.readdata !== 32'h0) begin failures++; $display("FAIL reset_readdata got=%h exp=0", bus0.readdata); end
        reset = 1'b0;
        rd0(3'd0, rd);
        checks++; if (rd !== 32'h24) begin failures++; $display("FAIL reset_data_read got=%h exp=24", rd); end
        rd0(3'd2, rd);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL reset_mask_read got=%h exp=0", rd); end
    endtask

    task automatic test_edge_irq();
        wr0(3'd2, 32'h01);
        rd0(3'd2, rd);
        checks++; if (rd !== 32'h01) begin failures++; $display("FAIL mask_readback got=%h exp=01", rd); end
        in0 = 8'h01;
        tick(2);
        checks++; if (irq0 !== 1'b0) begin failures++; $display("FAIL irq_early got=%b exp=0", irq0); end
        tick();
        checks++; if (irq0 !== 1'b1) begin failures++; $display("FAIL irq_edge got=%b exp=1", irq0); end
        rd0(3'd3, rd);
        checks++; if (rd !== 32'h01) begin failures++; $display("FAIL edge_cap got=%h exp=01", rd); end
        wr0(3'd3, 32'h01);
        checks++; if (irq0 !== 1'b0) begin failures++; $display("FAIL irq_w1c got=%b exp=0", irq0); end
    endtask

    task automatic test_simultaneous();
        in0 = 8'h03;
        tick(3);
        rd0(3'd3, rd);
        checks++; if (rd !== 32'h02) begin failures++; $display("FAIL cap_bit1 got=%h exp=02", rd); end
        in0 = 8'h07;
        tick(2);
        wr0(3'd3, 32'h04);
        rd0(3'd3, rd);
        checks++; if (rd !== 32'h06) begin failures++; $display("FAIL edge_beats_clear got=%h exp=06", rd); end
        wr0(3'd3, 32'h02);
        rd0(3'd3, rd);
        checks++; if (rd !== 32'h04) begin failures++; $display("FAIL w1c_bit1 got=%h exp=04", rd); end
        wr0(3'd3, 32'hFF);
    endtask

    task automatic test_outputs();
        wr0(3'd0, 32'hF0);
        wr0(3'd4, 32'h03);
        checks++; if (out0 !== 8'hF3) begin failures++; $display("FAIL outset got=%h exp=f3", out0); end
        wr0(3'd5, 32'h30);
        checks++; if (out0 !== 8'hC3) begin failures++; $display("FAIL outclr got=%h exp=c3", out0); end
        rd0(3'd4, rd);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL outset_read got=%h exp=0", rd); end
        rd0(3'd5, rd);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL outclr_read got=%h exp=0", rd); end
        wr0(3'd6, 32'hFF);
        rd0(3'd6, rd);
        checks++; if (rd !== 32'h0 || out0 !== 8'hC3) begin failures++; $display("FAIL addr6 got=%h/%h exp=0/c3", rd, out0); end
    endtask

    task automatic test_direction();
        wr0(3'd1, 32'h0F);
        wr0(3'd0, 32'hAA);
        in0 = 8'h55;
        tick(2);
        rd0(3'd0, rd);
        checks++; if (rd !== 32'h5A) begin failures++; $display("FAIL data_mix got=%h exp=5a", rd); end
        checks++; if (oe0 !== 8'h0F) begin failures++; $display("FAIL oe got=%h exp=0f", oe0); end
        rd0(3'd1, rd);
        checks++; if (rd !== 32'h0F) begin failures++; $display("FAIL dir_read got=%h exp=0f", rd); end
    endtask

    task automatic test_level();
        wr1(3'd2, 32'h80);
        in1 = 8'h80;
        tick();
        checks++; if (irq1 !== 1'b0) begin failures++; $display("FAIL level_early got=%b exp=0", irq1); end
        tick();
        checks++; if (irq1 !== 1'b1) begin failures++; $display("FAIL level_high got=%b exp=1", irq1); end
        in1 = 8'h00;
        tick();
        checks++; if (irq1 !== 1'b1) begin failures++; $display("FAIL level_hold got=%b exp=1", irq1); end
        tick();
        checks++; if (irq1 !== 1'b0) begin failures++; $display("FAIL level_low got=%b exp=0", irq1); end
        rd1(3'd3, rd);
        checks++; if (rd !== 32'h80) begin failures++; $display("FAIL level_cap_any got=%h exp=80", rd); end
        in1 = 8'h80;
        tick(2);
        wr1(3'd1, 32'h80);
        checks++; if (irq1 !== 1'b0) begin failures++; $display("FAIL level_dir got=%b exp=0", irq1); end
    endtask

    task automatic test_reset_mid();
        in0 = 8'h00;
        tick(3);
        wr0(3'd2, 32'hFF);
        in0 = 8'hFF;
        tick(3);
        checks++; if (irq0 !== 1'b1) begin failures++; $display("FAIL pre_reset_irq got=%b exp=1", irq0); end
        bus0.address = 3'd3; bus0.writedata = 32'h12; bus0.chipselect = 1'b1; bus0.write_n = 1'b0;
        bus0.address = 3'd0;
        reset = 1'b1;
        tick();
        bus0.chipselect = 1'b0; bus0.write_n = 1'b1;
        checks++; if (out0 !== 8'hA5 || oe0 !== 8'h3C) begin failures++; $display("FAIL mid_reset_out got=%h/%h exp=a5/3c", out0, oe0); end
        checks++; if (irq0 !== 1'b0) begin failures++; $display("FAIL mid_reset_irq got=%b exp=0", irq0); end
        checks++; if (bus0.readdata !== 32'h0) begin failures++; $display("FAIL mid_reset_rd got=%h exp=0", bus0.readdata); end
        in0 = 8'h00;
        tick();
        reset = 1'b0;
        rd0(3'd3, rd);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL post_reset_cap got=%h exp=0", rd); end
        rd0(3'd2, rd);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL post_reset_mask got=%h exp=0", rd); end
    endtask

    initial begin
        test_reset();
        test_edge_irq();
        test_simultaneous();
        test_outputs();
        test_direction();
        test_level();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
